// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding, instruction width,
// PC step and the bubble encoding used by the pipeline front end.
package cpu_pkg;

  localparam int INST_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [INST_W-1:0] NOP_INST = '0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DROP
  } fetch_state_t;

  // Instruction addresses are word aligned; the low two bits are discarded.
  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// (master) and instruction memory (slave).
interface fetch_unit_if;
  import cpu_pkg::*;

  logic              req;
  logic [31:0]       addr;
  logic              ack;
  logic [INST_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction and its pc while the
// consumer is stalled. Clear wins over load, load wins over unload.
module fetch_skid
  import cpu_pkg::*;
#(
  parameter int W = INST_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         unload_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  input  logic [31:0]  pc_i,
  output logic [W-1:0] data_o,
  output logic [31:0]  pc_o,
  output logic         full_o
);

  logic [W-1:0] data_q;
  logic [31:0]  pc_q;
  logic         full_q;

  // Capture an entry on load; drop it on clear or unload.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q <= '0;
      pc_q   <= '0;
      full_q <= 1'b0;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      data_q <= data_i;
      pc_q   <= pc_i;
      full_q <= 1'b1;
    end else if (unload_i) begin
      full_q <= 1'b0;
    end
  end

  assign data_o = data_q;
  assign pc_o   = pc_q;
  assign full_o = full_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake with
// instruction memory and presents pc/inst pairs to the IF/ID register.
// Stalls park a just-fetched instruction in a skid buffer; redirects flush
// everything and discard the data of any fetch still in flight.
// Optional macro FETCH_PERF_EN adds fetch and stall event counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0]       RESET_PC = 32'h0000_0000,
  parameter logic [INST_W-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               hazard_i,
  input  logic               redirect_i,
  input  logic [31:0]        target_i,
  fetch_unit_if.master       imem,
  output logic [31:0]        pc_o,
  output logic [INST_W-1:0]  inst_o,
  output logic               valid_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        fetch_cnt_o,
  output logic [31:0]        stall_cnt_o
`endif
);

  fetch_state_t      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       dropAddr_q, dropAddr_d;
  logic [31:0]       outPc_q, outPc_d;
  logic [INST_W-1:0] outInst_q, outInst_d;
  logic              outValid_q, outValid_d;
  logic [31:0]       pcPlus;
  logic              skidLoad, skidUnload, skidClear, skidFull;
  logic [INST_W-1:0] skidData;
  logic [31:0]       skidPc;

  assign pcPlus = pc_q + PC_STEP;

  // The request is live while fetching or while draining a wrong-path
  // fetch; during DROP the old address stays on the bus until the ack.
  assign imem.req  = (state_q == FETCH) || (state_q == DROP);
  assign imem.addr = (state_q == DROP) ? dropAddr_q : pc_q;

  fetch_skid #(.W(INST_W)) skid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (skidLoad),
    .unload_i (skidUnload),
    .clear_i  (skidClear),
    .data_i   (imem.rdata),
    .pc_i     (pcPlus),
    .data_o   (skidData),
    .pc_o     (skidPc),
    .full_o   (skidFull)
  );

  // Next-state, PC and output decode; redirect overrides every other event.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    dropAddr_d = dropAddr_q;
    outPc_d    = outPc_q;
    outInst_d  = outInst_q;
    outValid_d = outValid_q;
    skidLoad   = 1'b0;
    skidUnload = 1'b0;
    skidClear  = 1'b0;

    if (redirect_i) begin
      pc_d       = alignPc(target_i);
      outPc_d    = '0;
      outInst_d  = NOP_INST;
      outValid_d = 1'b0;
      skidClear  = 1'b1;
      if (imem.req && !imem.ack) begin
        state_d    = DROP;
        dropAddr_d = imem.addr;
      end else begin
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (imem.ack) begin
            pc_d = pcPlus;
            if (hazard_i) begin
              skidLoad = 1'b1;
              state_d  = HOLD;
            end else begin
              outPc_d    = pcPlus;
              outInst_d  = imem.rdata;
              outValid_d = 1'b1;
            end
          end else if (!hazard_i) begin
            outInst_d  = NOP_INST;
            outValid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!hazard_i) begin
            outPc_d    = skidPc;
            outInst_d  = skidFull ? skidData : NOP_INST;
            outValid_d = skidFull;
            skidUnload = 1'b1;
            state_d    = FETCH;
          end
        end
        DROP: begin
          if (imem.ack) begin
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, PC and registered IF/ID outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      dropAddr_q <= '0;
      outPc_q    <= '0;
      outInst_q  <= NOP_INST;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      dropAddr_q <= dropAddr_d;
      outPc_q    <= outPc_d;
      outInst_q  <= outInst_d;
      outValid_q <= outValid_d;
    end
  end

  assign pc_o    = outPc_q;
  assign inst_o  = outInst_q;
  assign valid_o = outValid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetchCnt_q, stallCnt_q;
  logic        deliver;

  assign deliver = (state_q == FETCH) && imem.ack && !redirect_i;

  // Count delivered fetches and stalled cycles; both wrap silently.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetchCnt_q <= '0;
      stallCnt_q <= '0;
    end else begin
      if (deliver) begin
        fetchCnt_q <= fetchCnt_q + 32'd1;
      end
      if (hazard_i) begin
        stallCnt_q <= stallCnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt_o = fetchCnt_q;
  assign stall_cnt_o = stallCnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit. A driver plays both the
// pipeline (hazard/redirect) and instruction memory; it predicts, at a
// program-order level, which fetched words must reach the IF/ID register
// and appends them to an expected list. A monitor pops that list whenever
// the consumer would take an instruction and checks handshake properties.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;
  localparam int MODE_ZW    = 0;
  localparam int MODE_LAT2  = 1;
  localparam int MODE_HOLD  = 2;
  localparam int MODE_REDIR = 3;
  localparam int MODE_RAND  = 4;
  localparam int MODE_SLOW  = 5;
  localparam int MODE_RST   = 6;
  localparam int EXP_DEPTH  = 8192;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] epoch;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic        hazard;
    logic        redirect;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } sample_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        hazard_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] target_i = '0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
`ifdef FETCH_PERF_EN
  logic [31:0] fetchCnt, stallCnt;
`endif

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(32'h0)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .hazard_i   (hazard_i),
    .redirect_i (redirect_i),
    .target_i   (target_i),
    .imem       (imem),
    .pc_o       (pc_o),
    .inst_o     (inst_o),
    .valid_o    (valid_o)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt_o (fetchCnt),
    .stall_cnt_o (stallCnt)
`endif
  );

  // Free-running 10-unit clock.
  initial forever #5 clk_i = ~clk_i;

  // Hard stop in case the run ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before the run completed");
    $fatal(1, "[TB] watchdog");
  end

  exp_t        expArr [EXP_DEPTH];
  int          writeIdx = 0;
  logic [31:0] drvEpoch = '0;
  logic [31:0] expNext = RESET_PC;
  bit          memPending = 1'b0;
  int          memRemain = 0;
  int          phase = MODE_RST;
  bit          done = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          consumed = 0;

  function automatic logic [31:0] memData(input logic [31:0] addr);
    return addr ^ 32'hC3A5_5A3C;
  endfunction

  function automatic int latency(input int mode);
    case (mode)
      MODE_ZW, MODE_HOLD: return 0;
      MODE_LAT2:          return 2;
      MODE_REDIR:         return 3;
      MODE_SLOW:          return 6;
      default:            return int'($urandom_range(0, 3));
    endcase
  endfunction

  // One stimulus cycle: memory response, hazard and redirect for the next
  // edge, plus the program-order prediction of what must be delivered.
  task automatic driveCycle(input int mode, input int cyc);
    logic        ack, hz, rd;
    logic [31:0] tgt, addr;
    @(posedge clk_i);
    #2;
    ack  = 1'b0;
    hz   = 1'b0;
    rd   = 1'b0;
    tgt  = target_i;
    addr = imem.addr;
    if (imem.req) begin
      if (!memPending) begin
        memPending = 1'b1;
        memRemain  = latency(mode);
      end
      if (memRemain == 0) begin
        ack        = 1'b1;
        memPending = 1'b0;
      end else begin
        memRemain--;
      end
    end
    if (mode == MODE_HOLD) begin
      hz = ((cyc % 8) >= 3) && ((cyc % 8) <= 5);
    end else if (mode == MODE_REDIR) begin
      if ((cyc % 9) == 4) begin
        tgt = 32'h100 | 32'($urandom_range(0, 3));
        rd  = ((tgt & 32'hFFFF_FFFC) != addr);
        hz  = ($urandom_range(0, 1) == 1);
      end
    end else if (mode == MODE_RAND) begin
      hz = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 6);
      if (rd) begin
        tgt = 32'($urandom_range(32'h1000, 32'hFFFF));
        if ((tgt & 32'hFFFF_FFFC) == addr) begin
          tgt = tgt + 32'h40;
        end
      end
    end
    imem.ack   = ack;
    imem.rdata = ack ? memData(addr) : $urandom;
    hazard_i   = hz;
    redirect_i = rd;
    target_i   = tgt;
    if (rd) begin
      drvEpoch = drvEpoch + 1;
      expNext  = tgt & 32'hFFFF_FFFC;
    end else if (ack && addr == expNext && writeIdx < EXP_DEPTH) begin
      expArr[writeIdx] = '{pc: expNext + 32'd4, inst: memData(expNext), epoch: drvEpoch};
      writeIdx++;
      expNext = expNext + 32'd4;
    end
  endtask

  task automatic applyStimulus(input int mode, input int cycles);
    phase = mode;
    for (int c = 0; c < cycles; c++) begin
      driveCycle(mode, c);
    end
  endtask

  // Asynchronous reset while a slow memory request is still waiting.
  task automatic resetMidWait();
    phase = MODE_SLOW;
    for (int c = 0; c < 20; c++) begin
      driveCycle(MODE_SLOW, c);
      if (memPending && memRemain >= 2) break;
    end
    @(posedge clk_i);
    #2;
    phase      = MODE_RST;
    rst_i      = 1'b0;
    memPending = 1'b0;
    imem.ack   = 1'b0;
    hazard_i   = 1'b0;
    redirect_i = 1'b0;
    drvEpoch   = drvEpoch + 1;
    expNext    = RESET_PC;
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
  endtask

  // Driver: reset, then directed phases followed by random traffic.
  initial begin
    imem.ack   = 1'b0;
    imem.rdata = '0;
    repeat (3) @(posedge clk_i);
    #2;
    phase = MODE_ZW;
    rst_i = 1'b1;
    applyStimulus(MODE_ZW, 30);
    applyStimulus(MODE_LAT2, 20);
    applyStimulus(MODE_HOLD, 40);
    applyStimulus(MODE_REDIR, 60);
    applyStimulus(MODE_RAND, 2000);
    resetMidWait();
    applyStimulus(MODE_RAND, 300);
    done = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic sample_t takeSample();
    sample_t s;
    s.rst      = rst_i;
    s.req      = imem.req;
    s.addr     = imem.addr;
    s.ack      = imem.ack;
    s.hazard   = hazard_i;
    s.redirect = redirect_i;
    s.valid    = valid_o;
    s.pc       = pc_o;
    s.inst     = inst_o;
    return s;
  endfunction

  // Monitor: at each falling edge compare the last clock edge's effect
  // (prev sample -> cur sample) against the scoreboard and properties.
  initial begin
    sample_t     prev, cur;
    int          prevPhase, phaseSamples, readIdx;
    logic [31:0] monEpoch;
    prev = '0;
    prevPhase = -1;
    phaseSamples = 0;
    readIdx = 0;
    monEpoch = '0;
    while (!done) begin
      @(negedge clk_i);
      cur = takeSample();
      phaseSamples = (phase == prevPhase) ? phaseSamples + 1 : 1;
      prevPhase = phase;
      if (!cur.rst) begin
        if (prev.rst) monEpoch = monEpoch + 1;
        checkOutput("reset_req", 32'(cur.req), 32'h0);
        checkOutput("reset_valid", 32'(cur.valid), 32'h0);
        checkOutput("reset_pc", cur.pc, 32'h0);
        checkOutput("reset_inst", cur.inst, 32'h0);
      end else if (prev.rst) begin
        if (prev.valid && !prev.hazard && !prev.redirect) begin
          consumed++;
          while (readIdx < writeIdx && expArr[readIdx].epoch != monEpoch) readIdx++;
          if (readIdx < writeIdx) begin
            checkOutput("consume_pc", prev.pc, expArr[readIdx].pc);
            checkOutput("consume_inst", prev.inst, expArr[readIdx].inst);
            readIdx++;
          end else begin
            checks++;
            errors++;
            $display("[TB] FAIL consume_unexpected actual pc=%h inst=%h required none at %0t",
                     prev.pc, prev.inst, $time);
          end
        end
        if (prev.redirect) begin
          monEpoch = monEpoch + 1;
          checkOutput("redirect_valid", 32'(cur.valid), 32'h0);
          checkOutput("redirect_pc", cur.pc, 32'h0);
          checkOutput("redirect_inst", cur.inst, 32'h0);
        end else if (prev.hazard) begin
          checkOutput("stall_valid", 32'(cur.valid), 32'(prev.valid));
          checkOutput("stall_pc", cur.pc, prev.pc);
          checkOutput("stall_inst", cur.inst, prev.inst);
        end
        if (prev.req && !prev.ack) begin
          checkOutput("req_held", 32'(cur.req), 32'h1);
          checkOutput("addr_held", cur.addr, prev.addr);
        end
        if (!cur.valid) begin
          checkOutput("bubble_nop", cur.inst, 32'h0);
        end
        if (phase == MODE_ZW && phaseSamples >= 3) begin
          checkOutput("zero_wait_throughput", 32'(cur.valid), 32'h1);
        end
      end
      prev = cur;
    end
    checks++;
    if (consumed < 200) begin
      errors++;
      $display("[TB] FAIL delivered_count actual=%0d required>=200", consumed);
    end
    $display("[TB] run complete, %0d instructions consumed", consumed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
